// File: rtl/layer1_relu.sv
// Layer-1 activation stage: per-channel bias add, requantisation to 16-bit
// fixed point, ReLU with saturation, and pixel column/row indexing for the
// downstream max-pool stage. Three register stages, fixed latency of 3 clocks.
module layer1_relu #(
    parameter int CH     = 16,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 8,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 conv_vsync,
    input  logic                 conv_href,
    input  logic [CH*ACC_W-1:0]  conv_data,
    input  logic [CH*16-1:0]     bias,
    output logic                 relu_vsync,
    output logic                 relu_href,
    output logic [6:0]           relu_h_cnt,
    output logic [6:0]           relu_v_cnt,
    output logic [CH*16-1:0]     relu_data,
    output logic                 relu_done
);

    localparam int OUT_W = 16;
    // One guard bit so the bias add can never overflow.
    localparam int SUM_W = ACC_W + 1;
    localparam logic [6:0] H_LAST = 7'(WIDTH - 1);
    localparam logic [6:0] V_LAST = 7'(HEIGHT - 1);
    localparam logic signed [SUM_W-1:0] Q_MAX = {{(SUM_W-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};

    // Bias is in output Q format; align it to the accumulator's fractional bits.
    function automatic logic signed [SUM_W-1:0] bias_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [OUT_W-1:0] b
    );
        logic signed [SUM_W-1:0] acc_x;
        logic signed [SUM_W-1:0] b_x;
        acc_x = {acc[ACC_W-1], acc};
        b_x   = {{(SUM_W-OUT_W){b[OUT_W-1]}}, b};
        return acc_x + (b_x <<< SHIFT);
    endfunction

    // Floor requantisation (arithmetic shift), then clamp to 0..32767.
    function automatic logic [OUT_W-1:0] relu_sat(
        input logic signed [SUM_W-1:0] s
    );
        logic signed [SUM_W-1:0] q;
        q = s >>> SHIFT;
        if (q[SUM_W-1]) begin
            return '0;
        end else if (q > Q_MAX) begin
            return Q_MAX[OUT_W-1:0];
        end else begin
            return q[OUT_W-1:0];
        end
    endfunction

    logic signed [SUM_W-1:0] sum_c  [CH];
    logic signed [SUM_W-1:0] sum_p0 [CH];
    logic                    vld_p0;
    logic                    vs_p0;

    logic [OUT_W-1:0]        q_c    [CH];
    logic [OUT_W-1:0]        q_p1   [CH];
    logic                    vld_p1;
    logic                    vs_p1;
    logic [6:0]              h_p1;
    logic [6:0]              v_p1;

    // Index the next valid pixel will receive.
    logic [6:0]              cnt_h;
    logic [6:0]              cnt_v;
    logic                    frame_start;
    logic [6:0]              idx_h;
    logic [6:0]              idx_v;

    // ---------------- stage 1: bias add ----------------

    // Per-lane bias add on the incoming accumulators.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            sum_c[k] = bias_add(conv_data[k*ACC_W +: ACC_W], bias[k*OUT_W +: OUT_W]);
        end
    end

    // Stage-1 registers; sums load only on a valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vs_p0  <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                sum_p0[k] <= '0;
            end
        end else begin
            vld_p0 <= conv_href;
            vs_p0  <= conv_vsync;
            if (conv_href) begin
                for (int k = 0; k < CH; k++) begin
                    sum_p0[k] <= sum_c[k];
                end
            end
        end
    end

    // ---------------- stage 2: requantise, ReLU, index ----------------

    // Vsync rising edge seen at this stage restarts indexing at (0,0).
    always_comb begin
        frame_start = vs_p0 & ~vs_p1;
        idx_h       = frame_start ? 7'd0 : cnt_h;
        idx_v       = frame_start ? 7'd0 : cnt_v;
        for (int k = 0; k < CH; k++) begin
            q_c[k] = relu_sat(sum_p0[k]);
        end
    end

    // Stage-2 registers plus the column/row counters that tag each pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vs_p1  <= 1'b0;
            h_p1   <= '0;
            v_p1   <= '0;
            cnt_h  <= '0;
            cnt_v  <= '0;
            for (int k = 0; k < CH; k++) begin
                q_p1[k] <= '0;
            end
        end else begin
            vld_p1 <= vld_p0;
            vs_p1  <= vs_p0;
            if (vld_p0) begin
                h_p1 <= idx_h;
                v_p1 <= idx_v;
                for (int k = 0; k < CH; k++) begin
                    q_p1[k] <= q_c[k];
                end
                if (idx_h == H_LAST) begin
                    cnt_h <= '0;
                    cnt_v <= (idx_v == V_LAST) ? 7'd0 : idx_v + 7'd1;
                end else begin
                    cnt_h <= idx_h + 7'd1;
                    cnt_v <= idx_v;
                end
            end else if (frame_start) begin
                cnt_h <= '0;
                cnt_v <= '0;
            end
        end
    end

    // ---------------- stage 3: output registers ----------------

    // Output registers; data and indices hold between valid pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_href  <= 1'b0;
            relu_vsync <= 1'b0;
            relu_h_cnt <= '0;
            relu_v_cnt <= '0;
            relu_data  <= '0;
        end else begin
            relu_href  <= vld_p1;
            relu_vsync <= vs_p1;
            if (vld_p1) begin
                relu_h_cnt <= h_p1;
                relu_v_cnt <= v_p1;
                for (int k = 0; k < CH; k++) begin
                    relu_data[k*OUT_W +: OUT_W] <= q_p1[k];
                end
            end
        end
    end

    // Frame-done pulse the cycle after the last pixel of a frame leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_done <= 1'b0;
        end else begin
            relu_done <= relu_href && (relu_h_cnt == H_LAST) && (relu_v_cnt == V_LAST);
        end
    end

endmodule

// File: tb/tb_layer1_relu.sv
// Self-checking bench for layer1_relu: directed vector table, directed
// multi-cycle sequences, and random traffic against a pixel-level model.
module tb_layer1_relu;

    localparam int CH     = 16;
    localparam int ACC_W  = 32;
    localparam int SHIFT  = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 16;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic                clk = 1'b0;
    logic                rst;
    logic                conv_vsync;
    logic                conv_href;
    logic [CH*ACC_W-1:0] conv_data;
    logic [CH*16-1:0]    bias;
    logic                relu_vsync;
    logic                relu_href;
    logic [6:0]          relu_h_cnt;
    logic [6:0]          relu_v_cnt;
    logic [CH*16-1:0]    relu_data;
    logic                relu_done;

    layer1_relu #(
        .CH(CH), .ACC_W(ACC_W), .SHIFT(SHIFT), .WIDTH(WIDTH), .HEIGHT(HEIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .conv_vsync(conv_vsync),
        .conv_href(conv_href),
        .conv_data(conv_data),
        .bias(bias),
        .relu_vsync(relu_vsync),
        .relu_href(relu_href),
        .relu_h_cnt(relu_h_cnt),
        .relu_v_cnt(relu_v_cnt),
        .relu_data(relu_data),
        .relu_done(relu_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic: floor((acc + bias*2^SHIFT) / 2^SHIFT), clamped.
    function automatic logic [15:0] golden(input logic signed [ACC_W-1:0] acc,
                                           input logic signed [15:0] b);
        longint scale;
        longint s;
        longint q;
        scale = longint'(1) << SHIFT;
        s = longint'(acc) + longint'(b) * scale;
        q = s / scale;
        if (s < 0 && (s % scale) != 0) q = q - 1;
        if (q < 0) return 16'd0;
        if (q > 32767) return 16'd32767;
        return 16'(q);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit               href;
        bit               vs;
        bit               last;
        int               h;
        int               v;
        logic [CH*16-1:0] data;
    } ent_t;

    ent_t             pipe [3];
    ent_t             e;
    int               pix_cnt;
    bit               prev_vs;
    bit               exp_href;
    bit               exp_vs;
    bit               exp_done;
    int               exp_h;
    int               exp_v;
    logic [CH*16-1:0] exp_data;

    always @(posedge clk) begin
        if (rst) begin
            e.href = 0; e.vs = 0; e.last = 0; e.h = 0; e.v = 0; e.data = '0;
            for (int i = 0; i < 3; i++) pipe[i] = e;
            pix_cnt = 0; prev_vs = 0;
            exp_href = 0; exp_vs = 0; exp_done = 0;
            exp_h = 0; exp_v = 0; exp_data = '0;
        end else begin
            exp_done = exp_href && pipe[2].last;
            if (conv_vsync && !prev_vs) pix_cnt = 0;
            prev_vs = conv_vsync;
            e.href = conv_href; e.vs = conv_vsync;
            e.last = 0; e.h = 0; e.v = 0; e.data = '0;
            if (conv_href) begin
                int n;
                n = pix_cnt % NPIX;
                e.h = n % WIDTH;
                e.v = n / WIDTH;
                e.last = (n == NPIX - 1);
                for (int k = 0; k < CH; k++)
                    e.data[k*16 +: 16] = golden($signed(conv_data[k*ACC_W +: ACC_W]),
                                                $signed(bias[k*16 +: 16]));
                pix_cnt++;
            end
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
            exp_href = pipe[2].href;
            exp_vs   = pipe[2].vs;
            if (pipe[2].href) begin
                exp_h = pipe[2].h; exp_v = pipe[2].v; exp_data = pipe[2].data;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_href", relu_href, exp_href);
            check("out_vsync", relu_vsync, exp_vs);
            check("out_h_cnt", relu_h_cnt, exp_h);
            check("out_v_cnt", relu_v_cnt, exp_v);
            check("out_done", relu_done, exp_done);
            total++;
            if (relu_data !== exp_data) begin
                bad++;
                $display("FAIL out_data: got %h expected %h", relu_data, exp_data);
            end
            if (relu_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [ACC_W-1:0] rnd_acc();
        logic signed [ACC_W-1:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return r >>> 7;
            default: return r >>> 10;
        endcase
    endfunction

    task automatic rand_data();
        for (int k = 0; k < CH; k++) conv_data[k*ACC_W +: ACC_W] = rnd_acc();
    endtask

    task automatic rand_bias();
        for (int k = 0; k < CH; k++)
            bias[k*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                           : 16'($urandom_range(0, 255)) - 16'd128;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        conv_href = 0; conv_vsync = 0;
        repeat (n) tick();
    endtask

    task automatic vsync_pulse();
        conv_href = 0; conv_vsync = 1; rand_bias();
        tick();
        conv_vsync = 0;
    endtask

    task automatic send_px(input int n, input int gap_pct);
        int sent;
        sent = 0;
        while (sent < n) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                conv_href = 0;
            end else begin
                conv_href = 1; rand_data(); sent++;
            end
            tick();
        end
        conv_href = 0;
    endtask

    typedef struct {
        logic [31:0] acc;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int d0;
        vt[0] = '{32'h00001280, 16'h0003, 16'h0015};
        vt[1] = '{32'hFFFFFE00, 16'h0001, 16'h0000};
        vt[2] = '{32'h7FFF0000, 16'h7FFF, 16'h7FFF};
        vt[3] = '{32'hFFFFFFFF, 16'h0000, 16'h0000};
        vt[4] = '{32'h000000FF, 16'h0001, 16'h0001};
        vt[5] = '{32'h00000000, 16'h8000, 16'h0000};
        vt[6] = '{32'h007FFF80, 16'h0000, 16'h7FFF};
        vt[7] = '{32'h00800000, 16'h0000, 16'h7FFF};

        rst = 1; conv_href = 0; conv_vsync = 0; conv_data = '0; bias = '0;
        tick();
        chk_en = 1;

        // Traffic during reset must not reach the outputs.
        conv_href = 1; conv_vsync = 1;
        repeat (4) begin
            rand_data();
            tick();
            check("rst_href", relu_href, 0);
            check("rst_vsync", relu_vsync, 0);
            check("rst_data_zero", (relu_data == '0), 1);
            check("rst_h_cnt", relu_h_cnt, 0);
            check("rst_v_cnt", relu_v_cnt, 0);
            check("rst_done", relu_done, 0);
        end

        // First valid after reset: exactly 3 cycles, index (0,0).
        rst = 0; conv_vsync = 0; conv_href = 1; rand_data();
        tick();
        conv_href = 0;
        tick();
        check("lat_href_early", relu_href, 0);
        tick();
        check("lat_href", relu_href, 1);
        check("lat_h_cnt", relu_h_cnt, 0);
        check("lat_v_cnt", relu_v_cnt, 0);
        idle(3);

        // Arithmetic vectors on channel 0.
        for (int i = 0; i < 8; i++) begin
            conv_href = 0; bias = '0; bias[15:0] = vt[i].b;
            tick();
            rand_data(); conv_data[31:0] = vt[i].acc; conv_href = 1;
            tick();
            conv_href = 0;
            tick();
            tick();
            check($sformatf("vec%0d_href", i), relu_href, 1);
            check($sformatf("vec%0d_ch0", i), relu_data[15:0], vt[i].exp);
        end
        idle(2);

        // All lanes distinct in one cycle.
        for (int k = 0; k < CH; k++) bias[k*16 +: 16] = 16'(k * 7) - 16'd40;
        tick();
        for (int k = 0; k < CH; k++)
            conv_data[k*ACC_W +: ACC_W] = 32'(k) * 32'h00031000 - 32'h00018000 + 32'(k * 17);
        conv_href = 1;
        tick();
        conv_href = 0;
        tick();
        tick();
        for (int k = 0; k < CH; k++)
            check($sformatf("lane%0d", k), relu_data[k*16 +: 16],
                  golden($signed(conv_data[k*ACC_W +: ACC_W]), $signed(bias[k*16 +: 16])));
        idle(3);

        // Full frame with gaps: exactly one done.
        d0 = done_cnt;
        vsync_pulse(); send_px(NPIX, 30); idle(6);
        check("frame_done_count", done_cnt - d0, 1);

        // Vsync coincident with the first pixel, back-to-back pixels.
        d0 = done_cnt;
        conv_vsync = 1; conv_href = 1; rand_data();
        tick();
        conv_vsync = 0;
        send_px(NPIX - 1, 0); idle(6);
        check("vs_px_done_count", done_cnt - d0, 1);

        // Truncated frame: no done; the restarted frame completes normally.
        d0 = done_cnt;
        vsync_pulse(); send_px(40, 20); vsync_pulse(); send_px(20, 20); idle(6);
        check("trunc_no_done", done_cnt - d0, 0);
        send_px(NPIX - 20, 20); idle(6);
        check("trunc_then_full_done", done_cnt - d0, 1);

        // Reset mid-frame, then a full frame without a vsync.
        vsync_pulse(); send_px(100, 10);
        rst = 1;
        tick();
        rst = 0;
        d0 = done_cnt;
        send_px(NPIX, 25); idle(6);
        check("rst_mid_done_count", done_cnt - d0, 1);

        // Extra pixels beyond one frame keep counting and pulse again.
        d0 = done_cnt;
        vsync_pulse(); send_px(2 * NPIX + 17, 10); idle(6);
        check("overrun_done_count", done_cnt - d0, 2);

        // Random frames with random gaps and biases.
        repeat (3) begin
            d0 = done_cnt;
            vsync_pulse(); send_px(NPIX, $urandom_range(0, 50)); idle(6);
            check("rand_frame_done", done_cnt - d0, 1);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer1_relu.md
Name: layer1_relu

Overview:
- Layer-1 activation stage. Sits between the layer-1 convolution accumulators and the layer-1 max-pool stage.
- Per clock, takes CH signed convolution accumulators. For each channel it adds a per-channel bias, requantises to 16-bit fixed point, then applies ReLU with saturation.
- Emits the pixel stream with vsync/href and column/row counters (relu_h_cnt, relu_v_cnt) that the pool stage consumes directly.

Parameters:
- CH, 16, number of feature channels processed in parallel.
- ACC_W, 32, width of each signed conv accumulator.
- SHIFT, 8, arithmetic right-shift for requantisation (accumulator fractional bits minus output fractional bits).
- WIDTH, 16, feature-map columns per row (must equal the pool stage WIDTH).
- HEIGHT, 16, feature-map rows per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high, single clock domain clk.
- conv_vsync  in  1  frame marker from conv; its rising edge starts a frame.
- conv_href  in  1  conv_data valid this cycle.
- conv_data  in  CH*ACC_W  packed signed accumulators; channel k occupies [k*ACC_W +: ACC_W].
- bias  in  CH*16  packed signed biases in output Q format; quasi-static, changes only while conv_href=0.
- relu_vsync  out  1  conv_vsync delayed 3 cycles.
- relu_href  out  1  conv_href delayed 3 cycles; relu_data valid.
- relu_h_cnt  out  7  column of the pixel currently on relu_data.
- relu_v_cnt  out  7  row of the pixel currently on relu_data.
- relu_data  out  CH*16  packed unsigned-valued results, 0..32767 per channel.
- relu_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, all pipeline registers 0, counters 0.
- Reset mid-frame discards all in-flight data. Outputs stay 0 until new conv_href arrives after rst deasserts. No relu_done is issued for the aborted frame.
- Pipeline: 3 stages, fixed latency 3 clocks for data, href and vsync alike. No backpressure; one pixel accepted per cycle when conv_href=1.
- S1 (bias add): sum_k = sext(acc_k) + (sext(bias_k) << SHIFT), computed at ACC_W+1 bits signed, so there is no overflow.
- S2 (requantise + ReLU + saturate): q_k = sum_k >>> SHIFT (arithmetic shift, floor rounding), then:
  - q_k < 0 -> 0
  - q_k > 32767 -> 32767
  - otherwise q_k[15:0]
- S3: registers data, href, vsync and counter values together.
- Non-valid cycles: relu_data holds its last value while relu_href=0 (the data registers load only on a valid stage-2 entry).
- Counters run on the stage-2 valid, so the index is aligned with the data.
  - Column counter increments per valid pixel; at WIDTH-1 it wraps to 0 and the row counter increments.
  - Row counter at HEIGHT-1, when the column wraps, wraps to 0 and raises relu_done.
  - relu_done pulses exactly 1 cycle, the cycle after the relu_href cycle carrying pixel (WIDTH-1, HEIGHT-1).
- href gaps (within or between rows) are allowed; counters hold during gaps.
- Frame sync: a rising edge on the delayed vsync at stage 2 forces both counters to 0. A pixel valid in that same cycle gets index (0,0). This takes priority over increment and wrap.
- Extra pixels beyond WIDTH*HEIGHT before the next vsync continue from (0,0) and pulse relu_done again at the next full frame count.
- relu_h_cnt and relu_v_cnt are 7 bits; WIDTH and HEIGHT must be ≤ 128.

Test Plan:
- Reset: drive conv_href=1 with data during rst=1 -> all outputs stay 0. First valid after deassert appears at relu_href exactly 3 cycles later with h_cnt=0, v_cnt=0.
- Arithmetic, SHIFT=8, channel 0:
  - acc=0x00001280, bias=0x0003 -> (0x1280+0x300)>>8 = 0x0015.
  - acc=-512, bias=1 -> 0 (ReLU).
  - acc=0x7FFF0000, bias=0x7FFF -> 32767 (saturate).
  - acc=-1, bias=0 -> 0 (floor to -1, then ReLU).
- Channel independence: distinct acc/bias on all 16 channels in one cycle -> each relu_data slice matches its own golden value; no cross-lane leakage.
- Counters: full 16x16 frame with random href gaps -> relu_h_cnt sequences 0..15 per row, relu_v_cnt 0..15. relu_done high exactly one cycle, right after the pixel at (15,15).
- vsync mid-frame: new conv_vsync rising edge after 40 pixels -> next pixel indexed (0,0). No relu_done is issued for the truncated frame.
- Reset mid-frame: assert rst after 100 pixels for 1 cycle, then send a full frame -> counters restart at (0,0). Exactly one relu_done, after pixel 256 of the new frame.
